// File: rtl/energy_detect_sequencer.sv
// Sequencer for the energy-detection datapath: feeds paired samples into the
// signal/noise square adders, closes the window, runs the comparator, reports.
module energy_detect_sequencer #(
  parameter int DATA_W    = 8,
  parameter int THRES_W   = 12,
  parameter int N_SAMPLES = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [THRES_W-1:0] thres_in,
  input  logic [DATA_W-1:0]  sig_real,
  input  logic [DATA_W-1:0]  sig_imag,
  input  logic [DATA_W-1:0]  noise_real,
  input  logic [DATA_W-1:0]  noise_imag,
  input  logic               sample_valid,
  output logic               sample_ack,
  output logic [DATA_W-1:0]  signal_in_real,
  output logic [DATA_W-1:0]  signal_in_imag,
  output logic [DATA_W-1:0]  noise_in_real,
  output logic [DATA_W-1:0]  noise_in_imag,
  output logic               ready_signal,
  output logic               ready_noise,
  output logic               done_signal,
  output logic               done_noise,
  input  logic               standby_signal,
  input  logic               standby_noise,
  input  logic               complete_signal,
  input  logic               complete_noise,
  output logic [THRES_W-1:0] thres,
  output logic               ready_comp,
  input  logic               comp_out,
  input  logic               comp_done,
  output logic               detect,
  output logic               result_valid,
  output logic               busy,
  output logic               error
);

  localparam int CNT_W = $clog2(N_SAMPLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FEED    = 3'd1;
  localparam logic [2:0] S_STROBE  = 3'd2;
  localparam logic [2:0] S_CLOSE   = 3'd3;
  localparam logic [2:0] S_COMPARE = 3'd4;
  localparam logic [2:0] S_REPORT  = 3'd5;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [TO_W-1:0]  tcnt;
  logic             lat_s;
  logic             lat_n;
  logic             to_tick;
  logic             to_fire;
  logic             both_cpl;
  logic             stall;

  assign stall      = sample_valid & ~(standby_signal & standby_noise);
  assign sample_ack = (state == S_FEED) & sample_valid & standby_signal & standby_noise;
  assign both_cpl   = (lat_s | complete_signal) & (lat_n | complete_noise);

  assign busy         = (state != S_IDLE);
  assign ready_signal = (state == S_STROBE);
  assign ready_noise  = (state == S_STROBE);
  // Each done drops independently once its own completion has been latched.
  assign done_signal  = (state == S_CLOSE) & ~lat_s;
  assign done_noise   = (state == S_CLOSE) & ~lat_n;
  assign ready_comp   = (state == S_COMPARE);
  assign result_valid = (state == S_REPORT);

  always_comb begin
    state_nxt = state;
    to_tick   = 1'b0;
    unique case (state)
      S_IDLE:    if (start) state_nxt = S_FEED;
      S_FEED: begin
        if (sample_ack) state_nxt = S_STROBE;
        else if (stall) to_tick = 1'b1;
      end
      S_STROBE:  state_nxt = (cnt == CNT_LAST) ? S_CLOSE : S_FEED;
      S_CLOSE: begin
        if (both_cpl) state_nxt = S_COMPARE;
        else          to_tick   = 1'b1;
      end
      S_COMPARE: begin
        if (comp_done) state_nxt = S_REPORT;
        else           to_tick   = 1'b1;
      end
      S_REPORT:  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    to_fire = to_tick & (tcnt == TO_LAST);
    // An expired wait still goes through REPORT so the run emits one verdict.
    if (to_fire) state_nxt = S_REPORT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      tcnt           <= '0;
      lat_s          <= 1'b0;
      lat_n          <= 1'b0;
      thres          <= '0;
      detect         <= 1'b0;
      error          <= 1'b0;
      signal_in_real <= '0;
      signal_in_imag <= '0;
      noise_in_real  <= '0;
      noise_in_imag  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)               tcnt <= '0;
      else if (to_tick && (tcnt != TO_MAX)) tcnt <= tcnt + 1'b1;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            thres <= thres_in;
            error <= 1'b0;
            cnt   <= '0;
          end
        end
        S_FEED: begin
          if (sample_ack) begin
            signal_in_real <= sig_real;
            signal_in_imag <= sig_imag;
            noise_in_real  <= noise_real;
            noise_in_imag  <= noise_imag;
          end
        end
        S_STROBE: begin
          cnt   <= cnt + 1'b1;
          lat_s <= 1'b0;
          lat_n <= 1'b0;
        end
        S_CLOSE: begin
          if (complete_signal) lat_s <= 1'b1;
          if (complete_noise)  lat_n <= 1'b1;
        end
        S_COMPARE: if (comp_done) detect <= comp_out;
        default: ;
      endcase

      if (to_fire) begin
        error  <= 1'b1;
        detect <= 1'b0;
      end
    end
  end

endmodule

// File: doc/energy_detect_sequencer.md
Name: energy_detect_sequencer

Overview:
- Cycle-accurate initiator for the energy-detection datapath.
- Accepts paired signal/noise complex samples from an upstream valid/ack stream and feeds them into two square_adder instances (signal and noise) using their ready/done handshake.
- Closes the accumulation window, triggers the comparator, and returns a single detect verdict per run.
- Replaces bench-driven sequencing of those blocks in the synthesized design.

Parameters:
- DATA_W, 8, width of each real/imag sample component
- THRES_W, 12, comparator threshold width
- N_SAMPLES, 16, samples accumulated per run (minimum 1)
- TIMEOUT, 255, maximum cycles spent waiting on any downstream response

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a run; honoured only in IDLE
- thres_in  in  THRES_W  threshold, latched on start
- sig_real, sig_imag, noise_real, noise_imag  in  DATA_W each  upstream sample pair
- sample_valid  in  1  upstream sample present
- sample_ack  out  1  sample consumed this cycle
- signal_in_real, signal_in_imag, noise_in_real, noise_in_imag  out  DATA_W each  registered data to adders
- ready_signal, ready_noise  out  1  one-cycle sample strobe to adders
- done_signal, done_noise  out  1  close accumulation window
- standby_signal, standby_noise  in  1  adder can accept a sample
- complete_signal, complete_noise  in  1  adder result valid
- thres  out  THRES_W  latched threshold to comparator
- ready_comp  out  1  comparator request
- comp_out, comp_done  in  1  comparator verdict and valid
- detect  out  1  verdict of last run
- result_valid  out  1  one-cycle pulse, verdict valid
- busy  out  1  run in progress
- error  out  1  sticky timeout flag, cleared on next accepted start

Behaviour:
- Reset (async): all outputs 0, data/thres registers 0, state IDLE, counters 0. Reset mid-run abandons the run with no result_valid.
- States: IDLE, FEED, STROBE, CLOSE, COMPARE, REPORT.
- IDLE: busy=0. On start, latch thres_in into thres, clear error, clear sample count, go to FEED.
- FEED:
  - sample_ack = sample_valid & standby_signal & standby_noise (combinational).
  - On ack, register all four components onto the data outputs and go to STROBE.
  - No timeout on sample_valid. Timeout counts only while sample_valid=1 and either standby is low.
- STROBE:
  - ready_signal = ready_noise = 1 for exactly one cycle; data held stable through the following cycle.
  - Increment count. If count reaches N_SAMPLES go to CLOSE, else go to FEED.
  - The earliest next sample_ack is 2 cycles after the previous ack.
- CLOSE:
  - Assert done_signal and done_noise on the cycle after the final strobe.
  - Latch each complete_* independently; responses may arrive in different cycles.
  - Deassert each done_* the cycle after its own complete_* is seen.
  - When both are latched, go to COMPARE.
- COMPARE:
  - ready_comp = 1 starting the cycle after both completes are latched.
  - Held high until comp_done = 1; on that cycle capture comp_out and go to REPORT.
- REPORT: detect = captured value, result_valid = 1 for one cycle, ready_comp = 0, go to IDLE.
- Timeout:
  - Counter resets on every state change.
  - If it reaches TIMEOUT in FEED (stalled standby), CLOSE, or COMPARE: error = 1, detect = 0, result_valid pulses one cycle, all ready_*/done_*/ready_comp drop, go to IDLE.
- start while busy: ignored. start coinciding with REPORT: ignored.
- Simultaneous complete_signal and complete_noise: both latched in the same cycle, so COMPARE is entered after 1 cycle.
- Widths: sample count is clog2(N_SAMPLES+1) bits; timeout counter is clog2(TIMEOUT+1) bits and saturates.

Test Plan:
- N_SAMPLES=2, thres_in=12'h0C1; samples (8'h33, 8'h33, 8'h33, 8'h33) then (8'hB3, 8'h73, 8'h37, 8'h3B); standbys tied 1; completes return 3 cycles after done; comparator stub returns comp_out=1 after 2 cycles -> exactly 2 ready pulses per adder with matching data, thres=12'h0C1, detect=1, one result_valid pulse, busy drops afterwards.
- sample_valid gaps of 5 cycles between samples -> no extra ready pulses, no timeout, same result.
- complete_noise arrives 4 cycles after complete_signal -> done_signal drops first, done_noise drops later, ready_comp rises exactly 1 cycle after complete_noise.
- complete_noise never asserted, TIMEOUT=10 -> error=1, detect=0, result_valid pulse 10 cycles into CLOSE, all handshakes low; next start clears error.
- start pulsed mid-FEED, and start during REPORT -> both ignored, count unaffected.
- rst asserted during COMPARE -> all outputs 0 immediately, no result_valid; a fresh start runs normally.
